// File: rtl/conv1d_pkg.sv
// Shared constants, sizing functions and FSM state type for the 1-D convolution
// window generator.
package conv1d_pkg;

  typedef enum logic [1:0] {
    PAD_L = 2'd0,
    DATA  = 2'd1,
    PAD_R = 2'd2
  } state_t;

  function automatic int span_of(int kernel_size, int dilation);
    return (kernel_size - 1) * dilation + 1;
  endfunction

  function automatic int l_pad_of(int seq_len, int padding);
    return seq_len + 2 * padding;
  endfunction

  function automatic int l_out_of(int seq_len, int padding, int kernel_size,
                                  int dilation, int stride);
    return (l_pad_of(seq_len, padding) - span_of(kernel_size, dilation)) / stride + 1;
  endfunction

  function automatic bit span_fits(int kernel_size, int dilation, int seq_len,
                                   int padding);
    return span_of(kernel_size, dilation) <= l_pad_of(seq_len, padding);
  endfunction

endpackage

// File: rtl/conv1d_tap_shreg.sv
// SPAN-deep sample shift register with enable and sync clear; exposes the
// dilated taps of the window that includes the sample being pushed this cycle.
module conv1d_tap_shreg
  import conv1d_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int DILATION    = 1,
  parameter int SPAN        = span_of(KERNEL_SIZE, DILATION)
) (
  input  logic                          clk,
  input  logic                          clr_i,
  input  logic                          en_i,
  input  logic [DATA_W-1:0]             din_i,
  output logic [KERNEL_SIZE*DATA_W-1:0] taps_o
);

  // The incoming sample is the newest tap, so only SPAN-1 older words are stored.
  logic [DATA_W-1:0] view [SPAN];

  if (SPAN > 1) begin : g_hist
    logic [DATA_W-1:0] hist_q [SPAN-1];

    always_ff @(posedge clk) begin
      if (clr_i) begin
        for (int i = 0; i < SPAN - 1; i++) hist_q[i] <= '0;
      end else if (en_i) begin
        for (int i = 0; i < SPAN - 1; i++) hist_q[i] <= view[i+1];
      end
    end

    always_comb begin
      for (int i = 0; i < SPAN - 1; i++) view[i] = hist_q[i];
      view[SPAN-1] = din_i;
    end
  end else begin : g_nohist
    always_comb view[0] = din_i;
  end

  always_comb begin
    for (int k = 0; k < KERNEL_SIZE; k++) taps_o[k*DATA_W +: DATA_W] = view[k*DILATION];
  end

endmodule

// File: rtl/conv1d_window_gen.sv
// Turns a serial sample stream into parallel convolution windows with zero
// padding, dilation and stride; one window per valid/ready beat.
module conv1d_window_gen
  import conv1d_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int PADDING     = 0,
  parameter int DILATION    = 1,
  parameter int SEQ_LEN     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [KERNEL_SIZE*DATA_W-1:0] out_window,
  output logic                          out_last
);

  localparam int SPAN  = span_of(KERNEL_SIZE, DILATION);
  localparam int LPAD  = l_pad_of(SEQ_LEN, PADDING);
  localparam int LOUT  = l_out_of(SEQ_LEN, PADDING, KERNEL_SIZE, DILATION, STRIDE);
  localparam int P_W   = $clog2(LPAD + 1);
  localparam int PH_W  = $clog2(STRIDE + 1);
  localparam int WC_W  = $clog2(LOUT + 1);

  localparam logic [P_W-1:0]  P_LAST      = P_W'(LPAD - 1);
  localparam logic [P_W-1:0]  P_LPAD_END  = P_W'(PADDING - 1);
  localparam logic [P_W-1:0]  P_DATA_END  = P_W'(PADDING + SEQ_LEN - 1);
  localparam logic [P_W-1:0]  P_FIRST_WIN = P_W'(SPAN - 1);
  localparam logic [PH_W-1:0] PH_LAST     = PH_W'(STRIDE - 1);
  localparam logic [WC_W-1:0] WC_END      = WC_W'(LOUT);
  localparam logic [WC_W-1:0] WC_LAST     = WC_W'(LOUT - 1);

  if (!span_fits(KERNEL_SIZE, DILATION, SEQ_LEN, PADDING)) begin : g_bad_cfg
    $error("conv1d_window_gen: window span exceeds padded sequence length");
  end

  state_t                    state_q, state_d, st;
  logic [P_W-1:0]            p_q, p_d;
  logic [PH_W-1:0]           ph_q, ph_d;
  logic [WC_W-1:0]           win_q, win_d;
  logic                      ovalid_q, ovalid_d;
  logic                      olast_q, olast_d;
  logic [KERNEL_SIZE*DATA_W-1:0] owin_q, owin_d;
  logic                      adv_ok, adv, emit, wrap;
  logic [DATA_W-1:0]         push;
  logic [KERNEL_SIZE*DATA_W-1:0] taps;

  always_comb begin
    // With no padding, PAD_L is a zero-length state and behaves as DATA.
    st = state_q;
    if (state_q == PAD_L && PADDING == 0) st = DATA;
    adv_ok   = !ovalid_q || out_ready;
    in_ready = 1'b0;
    adv      = 1'b0;
    push     = '0;
    state_d  = state_q;
    case (st)
      PAD_L: begin
        adv = adv_ok;
        if (adv && p_q == P_LPAD_END) state_d = DATA;
      end
      DATA: begin
        in_ready = adv_ok && !rst;
        adv      = in_valid && adv_ok;
        push     = in_data;
        if (adv && p_q == P_DATA_END) state_d = (PADDING == 0) ? PAD_L : PAD_R;
      end
      PAD_R: begin
        adv = adv_ok;
        if (adv && p_q == P_LAST) state_d = PAD_L;
      end
      default: state_d = PAD_L;
    endcase

    wrap  = adv && (p_q == P_LAST);
    emit  = adv && (p_q >= P_FIRST_WIN) && (ph_q == '0) && (win_q != WC_END);
    p_d   = wrap ? '0 : (adv ? p_q + P_W'(1) : p_q);
    ph_d  = ph_q;
    if (wrap) ph_d = '0;
    else if (adv && p_q >= P_FIRST_WIN) ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
    win_d = wrap ? '0 : (emit ? win_q + WC_W'(1) : win_q);

    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    owin_d   = owin_q;
    if (emit) begin
      ovalid_d = 1'b1;
      owin_d   = taps;
      olast_d  = (win_q == WC_LAST);
    end else if (out_ready) begin
      ovalid_d = 1'b0;
      olast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PAD_L;
      p_q      <= '0;
      ph_q     <= '0;
      win_q    <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      owin_q   <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      ph_q     <= ph_d;
      win_q    <= win_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      owin_q   <= owin_d;
    end
  end

  conv1d_tap_shreg #(
    .DATA_W      (DATA_W),
    .KERNEL_SIZE (KERNEL_SIZE),
    .DILATION    (DILATION),
    .SPAN        (SPAN)
  ) u_shreg (
    .clk    (clk),
    .clr_i  (rst || wrap),
    .en_i   (adv),
    .din_i  (push),
    .taps_o (taps)
  );

  assign out_valid  = ovalid_q;
  assign out_last   = olast_q;
  assign out_window = owin_q;

endmodule

// File: tb/tb_conv1d_window_gen.sv
// Directed/random stimulus on three configurations with a queue scoreboard.
module tb_conv1d_window_gen;

  typedef struct packed {
    logic [95:0] win;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst        [3];
  logic        in_valid   [3];
  logic        in_ready   [3];
  logic [31:0] in_data    [3];
  logic        out_valid  [3];
  logic        out_ready  [3];
  logic [95:0] out_window [3];
  logic        out_last   [3];

  exp_t sb [3][$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   nwin      [3];
  int   first_cyc [3];
  int   last_cyc  [3];
  int   acc_cyc   [3][64];

  // A: K3 S1 P0 D1 L8   B: K3 S1 P1 D1 L8   C: K3 S2 P0 D2 L9
  conv1d_window_gen #(.DATA_W(32), .KERNEL_SIZE(3), .STRIDE(1), .PADDING(0),
                      .DILATION(1), .SEQ_LEN(8)) dut_a (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_window(out_window[0]), .out_last(out_last[0]));

  conv1d_window_gen #(.DATA_W(32), .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1),
                      .DILATION(1), .SEQ_LEN(8)) dut_b (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_window(out_window[1]), .out_last(out_last[1]));

  conv1d_window_gen #(.DATA_W(32), .KERNEL_SIZE(3), .STRIDE(2), .PADDING(0),
                      .DILATION(2), .SEQ_LEN(9)) dut_c (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_window(out_window[2]), .out_last(out_last[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] w3(int a, int b, int c);
    return {32'(c), 32'(b), 32'(a)};
  endfunction

  // Golden model: build the zero-padded sequence and slice every window from it.
  function automatic void push_model(int d, int first, int k, int s, int p,
                                     int dil, int l);
    int   xpad[$];
    int   span, lo;
    exp_t e;
    for (int i = 0; i < p; i++) xpad.push_back(0);
    for (int i = 0; i < l; i++) xpad.push_back(first + i);
    for (int i = 0; i < p; i++) xpad.push_back(0);
    span = (k - 1) * dil + 1;
    lo   = (xpad.size() - span) / s + 1;
    for (int w = 0; w < lo; w++) begin
      e.win = '0;
      for (int t = 0; t < k; t++) e.win[t*32 +: 32] = 32'(xpad[w*s + t*dil]);
      e.last = (w == lo - 1);
      sb[d].push_back(e);
    end
  endfunction

  task automatic push_const(int d, logic [95:0] win, logic last);
    exp_t e;
    e.win  = win;
    e.last = last;
    sb[d].push_back(e);
  endtask

  task automatic send(int d, int first, int n, int vgap, int rgap);
    int   i = 0;
    int   guard = 0;
    logic hs;
    while (i < n && guard < 1000) begin
      in_valid[d]  = (int'($urandom_range(99)) >= vgap);
      out_ready[d] = (int'($urandom_range(99)) >= rgap);
      in_data[d]   = 32'(first + i);
      @(negedge clk);
      hs = in_valid[d] && in_ready[d];
      @(posedge clk); #1;
      guard++;
      if (hs) begin
        acc_cyc[d][i] = cyc;
        i++;
      end
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    check_val("send_done", i, n);
  endtask

  task automatic drain(int d);
    int g = 0;
    out_ready[d] = 1'b1;
    while (sb[d].size() != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check_val("drain_empty", sb[d].size(), 0);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst[d] === 1'b0 && out_valid[d] === 1'b1 && out_ready[d] === 1'b1) begin
        check_val($sformatf("sb%0d_pending", d), sb[d].size() > 0, 1);
        if (sb[d].size() > 0) begin
          mon_e = sb[d].pop_front();
          check_val($sformatf("sb%0d_window", d), out_window[d], mon_e.win);
          check_val($sformatf("sb%0d_last", d), out_last[d], mon_e.last);
        end
        if (nwin[d] == 0) first_cyc[d] = cyc;
        last_cyc[d] = cyc;
        nwin[d]++;
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
      nwin[d] = 0; first_cyc[d] = 0; last_cyc[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_val($sformatf("rst%0d_out_valid", d), out_valid[d], 1'b0);
      check_val($sformatf("rst%0d_out_last", d), out_last[d], 1'b0);
      check_val($sformatf("rst%0d_out_window", d), out_window[d], '0);
      check_val($sformatf("rst%0d_in_ready", d), in_ready[d], 1'b0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0; out_ready[d] = 1'b1;
    end

    // Basic ramp, full rate, latency of one cycle.
    push_model(0, 1, 3, 1, 0, 1, 8);
    nwin[0] = 0;
    send(0, 1, 8, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_val("t1_nwin", nwin[0], 6);
    check_val("t1_latency", first_cyc[0], acc_cyc[0][2]);
    check_val("t1_full_rate", last_cyc[0] - first_cyc[0], 5);
    drain(0);

    // Padding: in_ready low for the pad slots around the data.
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    check_val("t2_pad_l_ready", in_ready[1], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t2_data_ready", in_ready[1], 1'b1);
    @(posedge clk); #1;
    push_model(1, 1, 3, 1, 1, 1, 8);
    nwin[1] = 0;
    send(1, 1, 8, 0, 0);
    @(negedge clk);
    check_val("t2_pad_r_ready", in_ready[1], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t2_pad_l2_ready", in_ready[1], 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t2_data2_ready", in_ready[1], 1'b1);
    @(posedge clk); #1;
    drain(1);
    check_val("t2_nwin", nwin[1], 8);

    // Stride 2 with dilation 2: last sample completes the last window.
    push_const(2, w3(1, 3, 5), 1'b0);
    push_const(2, w3(3, 5, 7), 1'b0);
    push_const(2, w3(5, 7, 9), 1'b1);
    nwin[2] = 0;
    send(2, 1, 9, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check_val("t3_nwin", nwin[2], 3);
    check_val("t3_last_latency", last_cyc[2], acc_cyc[2][8]);
    drain(2);

    // Backpressure mid-stream.
    push_model(0, 11, 3, 1, 0, 1, 8);
    send(0, 11, 4, 0, 0);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 32'd15;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("t4_hold_valid", out_valid[0], 1'b1);
      check_val("t4_hold_window", out_window[0], w3(12, 13, 14));
      check_val("t4_hold_last", out_last[0], 1'b0);
      check_val("t4_hold_in_ready", in_ready[0], 1'b0);
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    send(0, 15, 4, 0, 0);
    drain(0);

    // Reset mid-sequence discards the partial sequence.
    push_const(0, w3(51, 52, 53), 1'b0);
    send(0, 51, 4, 0, 0);
    out_ready[0] = 1'b0;
    rst[0]       = 1'b1;
    @(negedge clk);
    check_val("t5_rst_in_ready", in_ready[0], 1'b0);
    @(posedge clk); #1;
    rst[0]       = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check_val("t5_rst_out_valid", out_valid[0], 1'b0);
    check_val("t5_rst_out_window", out_window[0], '0);
    check_val("t5_rst_out_last", out_last[0], 1'b0);
    @(posedge clk); #1;
    push_model(0, 100, 3, 1, 0, 1, 8);
    send(0, 100, 8, 0, 0);
    drain(0);

    // Two padded sequences back-to-back with random gaps on both sides.
    push_model(1, 200, 3, 1, 1, 1, 8);
    push_model(1, 300, 3, 1, 1, 1, 8);
    send(1, 200, 8, 30, 30);
    send(1, 300, 8, 30, 30);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
